// File: rtl/case_1_mul_arb.sv
// Round-robin arbiter feeding one shared signed multiplier through a two-stage
// valid/ready pipeline (S1 operands, S2 product).
module case_1_mul_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 8,
  parameter int B_W     = 7,
  parameter int P_W     = 11
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  output logic [P_W-1:0]         resp_data,
  output logic [ID_W-1:0]        resp_id,
  input  logic                   resp_ready,
  output logic                   busy
);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [A_W-1:0]  a;
    logic [B_W-1:0]  b;
  } s1_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [P_W-1:0]  prod;
  } s2_t;

  s1_t s1;
  s2_t s2;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_found;
  logic [ID_W:0]   cand;
  logic [A_W-1:0]  a_sel;
  logic [B_W-1:0]  b_sel;
  logic [P_W-1:0]  prod;
  logic            s1_adv;
  logic            s2_adv;
  logic            accept;

  assign s2_adv = !s2.valid || resp_ready;
  assign s1_adv = !s1.valid || s2_adv;

  // Search starts at ptr; one extra bit on cand keeps the wrap exact when
  // NUM_REQ is not a power of two.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ))
        cand = cand - (ID_W+1)'(NUM_REQ);
      if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == gnt_id) begin
        a_sel = req_a[k*A_W +: A_W];
        b_sel = req_b[k*B_W +: B_W];
      end
    end
  end

  assign accept  = gnt_found && s1_adv && !ap_rst;
  assign ptr_nxt = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[gnt_id] = 1'b1;
  end

  // Low P_W bits of the signed product only depend on operands sign-extended
  // to P_W, so the full A_W+B_W product is never materialised.
  assign prod = P_W'($signed(s1.a)) * P_W'($signed(s1.b));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1  <= '0;
      s2  <= '0;
      ptr <= '0;
    end else begin
      if (s1_adv) begin
        s1.valid <= accept;
        if (accept) begin
          s1.id <= gnt_id;
          s1.a  <= a_sel;
          s1.b  <= b_sel;
        end
      end
      if (s2_adv) begin
        s2.valid <= s1.valid;
        if (s1.valid) begin
          s2.id   <= s1.id;
          s2.prod <= prod;
        end
      end
      if (accept)
        ptr <= ptr_nxt;
    end
  end

  assign resp_valid = s2.valid;
  assign resp_data  = s2.prod;
  assign resp_id    = s2.id;
  assign busy       = s1.valid || s2.valid;

endmodule

// File: tb/tb_case_1_mul_arb.sv
// Directed bench for case_1_mul_arb: reset, single request, wrap, fairness,
// backpressure and mid-flight reset, each with hand-computed expectations.
module tb_case_1_mul_arb;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int A_W     = 8;
  localparam int B_W     = 7;
  localparam int P_W     = 11;

  logic                   ap_clk;
  logic                   ap_rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   resp_valid;
  logic [P_W-1:0]         resp_data;
  logic [ID_W-1:0]        resp_id;
  logic                   resp_ready;
  logic                   busy;

  int errors = 0;
  int checks = 0;

  case_1_mul_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
    .resp_ready(resp_ready), .busy(busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_valid[i]       = 1'b1;
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    #3;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (resp_data !== 11'h000) begin errors++; $display("FAIL rst_resp_data got %h exp 000", resp_data); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL rst_resp_id got %0d exp 0", resp_id); end
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
    req_valid = '0;
    step();
    ap_rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_req_ready got %b exp 0000", req_ready); end
  endtask

  task automatic test_single();
    resp_ready = 1'b1;
    set_req(1, 8'sd5, -7'sd3);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant got %b exp 0010", req_ready); end
    step();
    req_valid = '0;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_s1 got v=%b busy=%b exp v=0 busy=1", resp_valid, busy); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 11'h7F1 || resp_id !== 2'd1)
      begin errors++; $display("FAIL single_resp got v=%b d=%h id=%0d exp v=1 d=7f1 id=1", resp_valid, resp_data, resp_id); end
    step();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain got v=%b busy=%b exp 0 0", resp_valid, busy); end
  endtask

  // ptr is 2 here; requester 0 alone must still be found after wrapping.
  task automatic test_wrap();
    set_req(0, -8'sd128, -7'sd64);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant got %b exp 0001", req_ready); end
    step();
    set_req(0, 8'sd127, 7'sd63);
    step();
    req_valid = '0;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 11'h000 || resp_id !== 2'd0)
      begin errors++; $display("FAIL wrap_neg got v=%b d=%h id=%0d exp v=1 d=000 id=0", resp_valid, resp_data, resp_id); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 11'h741 || resp_id !== 2'd0)
      begin errors++; $display("FAIL wrap_pos got v=%b d=%h id=%0d exp v=1 d=741 id=0", resp_valid, resp_data, resp_id); end
    step();
  endtask

  task automatic test_fairness();
    logic [NUM_REQ-1:0] exp_rdy;
    logic [P_W-1:0]     exp_d;
    ap_rst = 1'b1; #1; ap_rst = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, A_W'(i+1), B_W'(2));
    #1;
    for (int c = 0; c < 8; c++) begin
      exp_rdy = '0;
      exp_rdy[c % 4] = 1'b1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_grant c=%0d got %b exp %b", c, req_ready, exp_rdy); end
      if (c >= 2) begin
        exp_d = P_W'(2 * (((c-2) % 4) + 1));
        checks++; if (resp_valid !== 1'b1 || resp_id !== ID_W'((c-2) % 4) || resp_data !== exp_d)
          begin errors++; $display("FAIL fair_resp c=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", c, resp_valid, resp_id, resp_data, (c-2) % 4, exp_d); end
      end
      step();
    end
    req_valid = '0;
    step(); step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_drain got busy=%b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    set_req(2, 8'sd3, 7'sd4);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant0 got %b exp 0100", req_ready); end
    step();
    set_req(2, 8'sd5, 7'sd6);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant1 got %b exp 0100", req_ready); end
    step();
    set_req(2, 8'sd7, 7'sd8);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_data !== 11'd12 || resp_id !== 2'd2)
        begin errors++; $display("FAIL bp_hold c=%0d got rdy=%b v=%b d=%h id=%0d exp rdy=0000 v=1 d=00c id=2", c, req_ready, resp_valid, resp_data, resp_id); end
      if (c < 2) step();
    end
    req_valid = '0;
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_novalid got %b exp 0000", req_ready); end
    step();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 11'd30 || resp_id !== 2'd2)
      begin errors++; $display("FAIL bp_second got v=%b d=%h id=%0d exp v=1 d=01e id=2", resp_valid, resp_data, resp_id); end
    step();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%b busy=%b exp 0 0", resp_valid, busy); end
  endtask

  // Two accepts from requester 1 leave ptr at 2, so a grant to 0 proves the reset.
  task automatic test_reset_midflight();
    resp_ready = 1'b0;
    set_req(1, 8'sd9, 7'sd9);
    step();
    step();
    checks++; if (resp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_full got v=%b busy=%b exp 1 1", resp_valid, busy); end
    ap_rst = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || resp_data !== 11'h000)
      begin errors++; $display("FAIL mid_rst got v=%b busy=%b rdy=%b d=%h exp 0 0 0000 000", resp_valid, busy, req_ready, resp_data); end
    #1;
    ap_rst = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_stale c=%0d got v=%b busy=%b exp 0 0", c, resp_valid, busy); end
    end
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'sd2, 7'sd3);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b exp 0001", req_ready); end
    step();
    req_valid = '0;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 11'd6)
      begin errors++; $display("FAIL mid_resp got v=%b id=%0d d=%h exp v=1 id=0 d=006", resp_valid, resp_id, resp_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
